axi_slv_aw_w_arbiter: RTL and testbench
=======================================

Name: axi_slv_aw_w_arbiter

Overview:
- Per-slave write-path scheduler inside the 4-master/4-slave AXI crossbar; one instance sits in front of each slave port.
- Arbitrates AW requests from the 4 masters round-robin and tags the forwarded AWID with the winning master's one-hot ID mask.
- Records grant order in an order FIFO, then routes W beats from masters to the slave strictly in AW-grant order, one burst at a time.

Parameters:
- AXI_ADDR_W, 8, address width.
- AXI_ID_W, 8, ID width; bits [7:4] carry the master one-hot mask (0x10/0x20/0x40/0x80), bits [3:0] the master-local ID.
- NUM_MST, 4, number of masters (fixed at 4 in this revision).
- ORDER_FIFO_DEPTH, 16, maximum outstanding write bursts whose W data is not yet complete.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- m_awvalid  in  4  per-master AW valid.
- m_awready  out  4  per-master AW ready.
- m_awid  in  4*AXI_ID_W  packed per-master AWID; master i occupies slice i.
- m_awaddr  in  4*AXI_ADDR_W  packed per-master AWADDR.
- m_awlen  in  4*8  packed per-master AWLEN.
- s_awvalid  out  1  AW valid to slave.
- s_awready  in  1  AW ready from slave.
- s_awid  out  AXI_ID_W  tagged ID.
- s_awaddr  out  AXI_ADDR_W  forwarded address.
- s_awlen  out  8  forwarded length.
- m_wvalid  in  4  per-master W valid.
- m_wlast  in  4  per-master W last.
- m_wready  out  4  per-master W ready.
- s_wvalid  out  1  W valid to slave.
- s_wlast  out  1  W last to slave.
- s_wready  in  1  W ready from slave.
- w_sel  out  2  current W source master index; drives the external WDATA/WSTRB mux.
- order_full  out  1  order FIFO full (status).

Behaviour:
- Reset (async assert, sync-to-aclk deassert handled upstream):
  - All outputs 0, including m_awready=0, s_awvalid=0, m_wready=0, w_sel=0, order_full=0.
  - RR pointer=0, FSM=ARB_IDLE, FIFO empty.
  - Reset mid-burst discards all outstanding AW and order state; no partial W beat is forwarded after reset.
- AW FSM states:
  - ARB_IDLE:
    - If any m_awvalid and !order_full, select winner g = first requesting master at or after the RR pointer (wrap 3→0).
    - Register g, awid, awaddr, awlen; go to ARB_HOLD.
    - Otherwise stay in ARB_IDLE.
  - ARB_HOLD:
    - s_awvalid=1 with the registered fields held stable until handshake.
    - m_awready[g] = s_awready (combinational); all other m_awready bits = 0.
    - On s_awvalid&&s_awready: push g into FIFO, pointer = (g+1) mod 4, go to ARB_IDLE.
    - No re-arbitration while in HOLD.
- AW latency: request in cycle N → s_awvalid in cycle N+1. Minimum 2 cycles per AW grant.
- s_awid: bits [7:4] = one-hot(g) (g=0→0x1 … g=3→0x8); bits [3:0] = m_awid[g][3:0]. The master's own upper 4 ID bits are ignored.
- Order FIFO:
  - Depth ORDER_FIFO_DEPTH; 2-bit entries; count width clog2(DEPTH)+1.
  - order_full = (count==DEPTH).
  - When full, ARB_IDLE does not grant; the full check uses the registered count, so a same-cycle pop does not unblock a grant.
  - Simultaneous push and pop: count unchanged.
- W routing:
  - When FIFO non-empty: h = head entry; w_sel=h; s_wvalid=m_wvalid[h]; s_wlast=m_wlast[h]; m_wready[h]=s_wready; other m_wready bits = 0.
  - When FIFO empty: s_wvalid=0, all m_wready=0, w_sel holds its last value.
  - Pop on s_wvalid&&s_wready&&s_wlast. The next burst's beat may pass in the following cycle.
  - W beats presented by a master before its AW grant are held (not accepted).
  - W for a grant may complete in the same cycle its AW handshakes only if it is already the head entry; otherwise it waits for earlier bursts.

Test Plan:
- Single write: master 2 requests awid=0x03, addr=0x84, len=3 → s_awvalid 1 cycle later, s_awid=0x43; 4 W beats forwarded with w_sel=2; FIFO empty after the 4th beat's wlast.
- Round-robin fairness: all 4 masters hold awvalid, s_awready=1 → grant order 0,1,2,3,0; each s_awid upper nibble 0x1,0x2,0x4,0x8 respectively.
- Slave backpressure: s_awready=0 for 5 cycles in ARB_HOLD → s_awvalid/addr/id stable; m_awready all 0; other masters are not granted.
- W ordering: grants m1(len=1) then m3(len=0); m3 presents W first → m3 stalled (m_wready[3]=0) until m1's wlast accepted; then m3's beat passes the next cycle.
- FIFO full: 16 AW grants with s_wready=0 → order_full=1, 17th request not granted; one wlast pop → 17th AW granted (s_awvalid asserted) 2 cycles later.
- Reset mid-operation: assert aresetn=0 during an ARB_HOLD and mid-W burst → all outputs 0 immediately; after release, pointer=0 and first grant goes to the lowest requesting master.

Source files
------------

// File: rtl/axi_slv_aw_w_arbiter_if.sv
// AW/W handshake bundle between the four crossbar masters and one slave port.
// The arbiter uses the slave modport; the surrounding crossbar uses the master modport.
interface axi_slv_aw_w_arbiter_if #(
  parameter int AXI_ADDR_W = 8,
  parameter int AXI_ID_W   = 8
);
  logic [3:0]              m_awvalid;
  logic [3:0]              m_awready;
  logic [4*AXI_ID_W-1:0]   m_awid;
  logic [4*AXI_ADDR_W-1:0] m_awaddr;
  logic [4*8-1:0]          m_awlen;

  logic                    s_awvalid;
  logic                    s_awready;
  logic [AXI_ID_W-1:0]     s_awid;
  logic [AXI_ADDR_W-1:0]   s_awaddr;
  logic [7:0]              s_awlen;

  logic [3:0]              m_wvalid;
  logic [3:0]              m_wlast;
  logic [3:0]              m_wready;

  logic                    s_wvalid;
  logic                    s_wlast;
  logic                    s_wready;

  logic [1:0]              w_sel;
  logic                    order_full;

  modport slave (
    input  m_awvalid, m_awid, m_awaddr, m_awlen, s_awready,
    input  m_wvalid, m_wlast, s_wready,
    output m_awready, s_awvalid, s_awid, s_awaddr, s_awlen,
    output m_wready, s_wvalid, s_wlast, w_sel, order_full
  );

  modport master (
    output m_awvalid, m_awid, m_awaddr, m_awlen, s_awready,
    output m_wvalid, m_wlast, s_wready,
    input  m_awready, s_awvalid, s_awid, s_awaddr, s_awlen,
    input  m_wready, s_wvalid, s_wlast, w_sel, order_full
  );
endinterface

// File: rtl/axi_slv_aw_w_arbiter.sv
// Per-slave write scheduler: round-robin AW arbitration with master-tagged IDs,
// and an order FIFO that steers W bursts to the slave in AW-grant order.
module axi_slv_aw_w_arbiter #(
  parameter int AXI_ADDR_W       = 8,
  parameter int AXI_ID_W         = 8,
  parameter int NUM_MST          = 4,
  parameter int ORDER_FIFO_DEPTH = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axi_slv_aw_w_arbiter_if.slave bus
);

  localparam int MST_W = $clog2(NUM_MST);
  localparam int LOC_W = AXI_ID_W - NUM_MST;
  localparam int PTR_W = $clog2(ORDER_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ORDER_FIFO_DEPTH);

  typedef enum logic {
    ARB_IDLE,
    ARB_HOLD
  } arb_state_e;

  arb_state_e            state_q, state_d;
  logic [MST_W-1:0]      rr_ptr_q;
  logic [MST_W-1:0]      gnt_q;
  logic [MST_W-1:0]      win;
  logic                  win_vld;
  logic [NUM_MST-1:0]    win_tag;
  logic                  aw_load;
  logic                  aw_push;
  logic [AXI_ID_W-1:0]   aw_id_q;
  logic [AXI_ADDR_W-1:0] aw_addr_q;
  logic [7:0]            aw_len_q;
  logic [NUM_MST-1:0]    m_awready;

  logic [MST_W-1:0]      fifo_mem [ORDER_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  order_full;
  logic                  head_vld;
  logic [MST_W-1:0]      head;
  logic [MST_W-1:0]      w_sel_q, w_sel_d;
  logic                  s_wvalid, s_wlast, w_pop;
  logic [NUM_MST-1:0]    m_wready;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ORDER_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Scan downward so the requester closest to the pointer is written last and wins.
  always_comb begin
    logic [MST_W-1:0] cand;
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cand    = rr_ptr_q;
    win_vld = 1'b0;
    win     = rr_ptr_q;
    for (int k = NUM_MST - 1; k >= 0; k--) begin
      cand = rr_ptr_q + MST_W'(k);
      if (bus.m_awvalid[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
    win_tag      = '0;
    win_tag[win] = 1'b1;
  end

  // The full check looks at the registered count, so a same-cycle pop never frees a slot early.
  always_comb begin
    state_d = state_q;
    aw_load = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (win_vld && !order_full) begin
          aw_load = 1'b1;
          state_d = ARB_HOLD;
        end
      end
      ARB_HOLD: begin
        if (bus.s_awready) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign aw_push = (state_q == ARB_HOLD) && bus.s_awready;

  always_comb begin
    m_awready = '0;
    if (state_q == ARB_HOLD) m_awready[gnt_q] = bus.s_awready;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ARB_IDLE;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      aw_id_q   <= '0;
      aw_addr_q <= '0;
      aw_len_q  <= '0;
    end else begin
      state_q <= state_d;
      if (aw_load) begin
        gnt_q     <= win;
        aw_id_q   <= {win_tag, bus.m_awid[int'(win)*AXI_ID_W +: LOC_W]};
        aw_addr_q <= bus.m_awaddr[int'(win)*AXI_ADDR_W +: AXI_ADDR_W];
        aw_len_q  <= bus.m_awlen[int'(win)*8 +: 8];
      end
      if (aw_push) rr_ptr_q <= gnt_q + 1'b1;
    end
  end

  // NOTE: the order memory has no reset; count_q==0 already marks every slot invalid.
  always_ff @(posedge aclk) begin
    if (aw_push) fifo_mem[wr_ptr_q] <= gnt_q;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      w_sel_q  <= '0;
    end else begin
      if (aw_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (w_pop)   rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({aw_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      w_sel_q <= w_sel_d;
    end
  end

  assign order_full = (count_q == FULL_CNT);
  assign head_vld   = (count_q != '0);

  // Only the head burst's master sees wready; beats from anyone else wait.
  always_comb begin
    head     = fifo_mem[rd_ptr_q];
    w_sel_d  = head_vld ? head : w_sel_q;
    s_wvalid = 1'b0;
    s_wlast  = 1'b0;
    m_wready = '0;
    if (head_vld) begin
      s_wvalid       = bus.m_wvalid[head];
      s_wlast        = bus.m_wlast[head];
      m_wready[head] = bus.s_wready;
    end
  end

  assign w_pop = s_wvalid && bus.s_wready && s_wlast;

  assign bus.m_awready  = m_awready;
  assign bus.s_awvalid  = (state_q == ARB_HOLD);
  assign bus.s_awid     = aw_id_q;
  assign bus.s_awaddr   = aw_addr_q;
  assign bus.s_awlen    = aw_len_q;
  assign bus.m_wready   = m_wready;
  assign bus.s_wvalid   = s_wvalid;
  assign bus.s_wlast    = s_wlast;
  assign bus.w_sel      = w_sel_d;
  assign bus.order_full = order_full;

  a_aw_stable: assert property (@(posedge aclk) disable iff (!aresetn)
    (bus.s_awvalid && !bus.s_awready) |=>
      (bus.s_awvalid && $stable(aw_id_q) && $stable(aw_addr_q) && $stable(aw_len_q)));

  a_push_has_room: assert property (@(posedge aclk) disable iff (!aresetn)
    aw_push |-> (count_q != FULL_CNT));

  a_count_bound: assert property (@(posedge aclk) disable iff (!aresetn)
    count_q <= FULL_CNT);

  a_awready_onehot: assert property (@(posedge aclk) disable iff (!aresetn)
    $onehot0(m_awready) && $onehot0(m_wready));

endmodule

// File: tb/tb_axi_slv_aw_w_arbiter.sv
// Directed bench for axi_slv_aw_w_arbiter: a per-cycle vector table plus
// hand-written sequences for order-FIFO full and reset during traffic.
module tb_axi_slv_aw_w_arbiter;

  logic aclk = 1'b0;
  logic aresetn = 1'b1;
  always #5 aclk = ~aclk;

  axi_slv_aw_w_arbiter_if #(.AXI_ADDR_W(8), .AXI_ID_W(8)) bus ();

  axi_slv_aw_w_arbiter #(
    .AXI_ADDR_W(8), .AXI_ID_W(8), .NUM_MST(4), .ORDER_FIFO_DEPTH(16)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .bus    (bus)
  );

  typedef struct {
    logic       rst_before;
    logic [3:0] awv;
    logic       sar;
    logic [3:0] wv;
    logic [3:0] wl;
    logic       swr;
    logic       e_awv;
    logic [1:0] e_g;
    logic [3:0] e_awr;
    logic       e_wv;
    logic       e_wl;
    logic [3:0] e_wr;
    logic [1:0] e_sel;
    logic       e_full;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_bad   = 0;

  // Hand-written per-master constants: local ID nibble, address, length.
  logic [3:0] exp_loc  [4] = '{4'h1, 4'h5, 4'h3, 4'hC};
  logic [7:0] exp_addr [4] = '{8'h10, 8'h20, 8'h84, 8'h30};
  logic [7:0] exp_len  [4] = '{8'd0, 8'd1, 8'd3, 8'd0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_id(input logic [1:0] g);
    logic [3:0] oh;
    oh = 4'b0001 << g;
    return {oh, exp_loc[g]};
  endfunction

  function automatic void add(input logic rst, input logic [3:0] awv, input logic sar,
                              input logic [3:0] wv, input logic [3:0] wl, input logic swr,
                              input logic e_awv, input logic [1:0] e_g, input logic [3:0] e_awr,
                              input logic e_wv, input logic e_wl, input logic [3:0] e_wr,
                              input logic [1:0] e_sel, input logic e_full);
    vec_t v;
    v.rst_before = rst; v.awv = awv; v.sar = sar; v.wv = wv; v.wl = wl; v.swr = swr;
    v.e_awv = e_awv; v.e_g = e_g; v.e_awr = e_awr; v.e_wv = e_wv; v.e_wl = e_wl;
    v.e_wr = e_wr; v.e_sel = e_sel; v.e_full = e_full;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic [3:0] awv, input logic sar, input logic [3:0] wv,
                       input logic [3:0] wl, input logic swr);
    bus.m_awvalid = awv;
    bus.s_awready = sar;
    bus.m_wvalid  = wv;
    bus.m_wlast   = wl;
    bus.s_wready  = swr;
  endtask

  // Starts and ends just after a rising edge.
  task automatic do_reset();
    drive(4'b0, 1'b0, 4'b0, 4'b0, 1'b0);
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " s_awvalid"},  32'(bus.s_awvalid),  32'd0);
    check({tag, " m_awready"},  32'(bus.m_awready),  32'd0);
    check({tag, " s_awid"},     32'(bus.s_awid),     32'd0);
    check({tag, " s_awaddr"},   32'(bus.s_awaddr),   32'd0);
    check({tag, " s_awlen"},    32'(bus.s_awlen),    32'd0);
    check({tag, " s_wvalid"},   32'(bus.s_wvalid),   32'd0);
    check({tag, " s_wlast"},    32'(bus.s_wlast),    32'd0);
    check({tag, " m_wready"},   32'(bus.m_wready),   32'd0);
    check({tag, " w_sel"},      32'(bus.w_sel),      32'd0);
    check({tag, " order_full"}, 32'(bus.order_full), 32'd0);
  endtask

  initial begin
    bus.m_awid   = {8'h9C, 8'h03, 8'hE5, 8'hF1};
    bus.m_awaddr = {8'h30, 8'h84, 8'h20, 8'h10};
    bus.m_awlen  = {8'd0, 8'd3, 8'd1, 8'd0};
    drive(4'b0, 1'b0, 4'b0, 4'b0, 1'b0);

    // Reset state with every input asserted.
    #1 aresetn = 1'b0;
    drive(4'b1111, 1'b1, 4'b1111, 4'b1111, 1'b1);
    #2 check_all_zero("reset");
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check_all_zero("reset_held");
    drive(4'b0, 1'b0, 4'b0, 4'b0, 1'b0);
    @(posedge aclk);
    #1 aresetn = 1'b1;

    // Single write: master 2, len 3.
    add(1, 4'b0100, 1, 4'b0000, 4'b0000, 1,  0, 0, 4'b0000,  0, 0, 4'b0000, 0, 0);
    add(0, 4'b0100, 1, 4'b0100, 4'b0000, 1,  1, 2, 4'b0100,  0, 0, 4'b0000, 0, 0);
    add(0, 4'b0000, 1, 4'b0100, 4'b0000, 1,  0, 0, 4'b0000,  1, 0, 4'b0100, 2, 0);
    add(0, 4'b0000, 1, 4'b0100, 4'b0000, 1,  0, 0, 4'b0000,  1, 0, 4'b0100, 2, 0);
    add(0, 4'b0000, 1, 4'b0100, 4'b0000, 1,  0, 0, 4'b0000,  1, 0, 4'b0100, 2, 0);
    add(0, 4'b0000, 1, 4'b0100, 4'b0100, 1,  0, 0, 4'b0000,  1, 1, 4'b0100, 2, 0);
    add(0, 4'b0000, 1, 4'b0100, 4'b0100, 1,  0, 0, 4'b0000,  0, 0, 4'b0000, 2, 0);
    // Round robin: all masters requesting, grant order 0,1,2,3,0.
    add(1, 4'b1111, 1, 4'b0000, 4'b0000, 0,  0, 0, 4'b0000,  0, 0, 4'b0000, 0, 0);
    add(0, 4'b1111, 1, 4'b0000, 4'b0000, 0,  1, 0, 4'b0001,  0, 0, 4'b0000, 0, 0);
    add(0, 4'b1111, 1, 4'b0000, 4'b0000, 0,  0, 0, 4'b0000,  0, 0, 4'b0000, 0, 0);
    add(0, 4'b1111, 1, 4'b0000, 4'b0000, 0,  1, 1, 4'b0010,  0, 0, 4'b0000, 0, 0);
    add(0, 4'b1111, 1, 4'b0000, 4'b0000, 0,  0, 0, 4'b0000,  0, 0, 4'b0000, 0, 0);
    add(0, 4'b1111, 1, 4'b0000, 4'b0000, 0,  1, 2, 4'b0100,  0, 0, 4'b0000, 0, 0);
    add(0, 4'b1111, 1, 4'b0000, 4'b0000, 0,  0, 0, 4'b0000,  0, 0, 4'b0000, 0, 0);
    add(0, 4'b1111, 1, 4'b0000, 4'b0000, 0,  1, 3, 4'b1000,  0, 0, 4'b0000, 0, 0);
    add(0, 4'b1111, 1, 4'b0000, 4'b0000, 0,  0, 0, 4'b0000,  0, 0, 4'b0000, 0, 0);
    add(0, 4'b1111, 1, 4'b0000, 4'b0000, 0,  1, 0, 4'b0001,  0, 0, 4'b0000, 0, 0);
    // Backpressure on m1's grant while m3 waits, then W ordering m1 before m3.
    add(1, 4'b1010, 1, 4'b0000, 4'b0000, 0,  0, 0, 4'b0000,  0, 0, 4'b0000, 0, 0);
    for (int k = 0; k < 5; k++)
      add(0, 4'b1010, 0, 4'b0000, 4'b0000, 0,  1, 1, 4'b0000,  0, 0, 4'b0000, 0, 0);
    add(0, 4'b1010, 1, 4'b0000, 4'b0000, 0,  1, 1, 4'b0010,  0, 0, 4'b0000, 0, 0);
    add(0, 4'b1000, 1, 4'b1000, 4'b1000, 1,  0, 0, 4'b0000,  0, 0, 4'b0010, 1, 0);
    add(0, 4'b1000, 1, 4'b1000, 4'b1000, 1,  1, 3, 4'b1000,  0, 0, 4'b0010, 1, 0);
    add(0, 4'b0000, 1, 4'b1010, 4'b1000, 1,  0, 0, 4'b0000,  1, 0, 4'b0010, 1, 0);
    add(0, 4'b0000, 1, 4'b1010, 4'b1010, 1,  0, 0, 4'b0000,  1, 1, 4'b0010, 1, 0);
    add(0, 4'b0000, 1, 4'b1000, 4'b1000, 1,  0, 0, 4'b0000,  1, 1, 4'b1000, 3, 0);
    add(0, 4'b0000, 1, 4'b1000, 4'b1000, 1,  0, 0, 4'b0000,  0, 0, 4'b0000, 3, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset();
      drive(vecs[i].awv, vecs[i].sar, vecs[i].wv, vecs[i].wl, vecs[i].swr);
      @(negedge aclk);
      check($sformatf("v%0d s_awvalid", i),  32'(bus.s_awvalid),  32'(vecs[i].e_awv));
      check($sformatf("v%0d m_awready", i),  32'(bus.m_awready),  32'(vecs[i].e_awr));
      check($sformatf("v%0d s_wvalid", i),   32'(bus.s_wvalid),   32'(vecs[i].e_wv));
      check($sformatf("v%0d s_wlast", i),    32'(bus.s_wlast),    32'(vecs[i].e_wl));
      check($sformatf("v%0d m_wready", i),   32'(bus.m_wready),   32'(vecs[i].e_wr));
      check($sformatf("v%0d w_sel", i),      32'(bus.w_sel),      32'(vecs[i].e_sel));
      check($sformatf("v%0d order_full", i), 32'(bus.order_full), 32'(vecs[i].e_full));
      if (vecs[i].e_awv) begin
        check($sformatf("v%0d s_awid", i),   32'(bus.s_awid),   32'(exp_id(vecs[i].e_g)));
        check($sformatf("v%0d s_awaddr", i), 32'(bus.s_awaddr), 32'(exp_addr[vecs[i].e_g]));
        check($sformatf("v%0d s_awlen", i),  32'(bus.s_awlen),  32'(exp_len[vecs[i].e_g]));
      end
      next_cycle();
    end

    // Order FIFO full: 16 grants from m0 with the slave refusing W.
    do_reset();
    drive(4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b0);
    for (int k = 0; k < 32; k++) begin
      @(negedge aclk);
      check($sformatf("fill%0d s_awvalid", k),  32'(bus.s_awvalid),  32'(k % 2));
      check($sformatf("fill%0d m_awready", k),  32'(bus.m_awready),  (k % 2 == 1) ? 32'h1 : 32'h0);
      check($sformatf("fill%0d order_full", k), 32'(bus.order_full), 32'd0);
      next_cycle();
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      check($sformatf("full%0d order_full", k), 32'(bus.order_full), 32'd1);
      check($sformatf("full%0d s_awvalid", k),  32'(bus.s_awvalid),  32'd0);
      check($sformatf("full%0d m_awready", k),  32'(bus.m_awready),  32'd0);
      check($sformatf("full%0d s_wvalid", k),   32'(bus.s_wvalid),   32'd1);
      check($sformatf("full%0d m_wready", k),   32'(bus.m_wready),   32'd0);
      next_cycle();
    end
    bus.s_wready = 1'b1;
    @(negedge aclk);
    check("pop m_wready",   32'(bus.m_wready),   32'h1);
    check("pop s_awvalid",  32'(bus.s_awvalid),  32'd0);
    check("pop order_full", 32'(bus.order_full), 32'd1);
    next_cycle();
    bus.s_wready = 1'b0;
    @(negedge aclk);
    check("pop+1 order_full", 32'(bus.order_full), 32'd0);
    check("pop+1 s_awvalid",  32'(bus.s_awvalid),  32'd0);
    next_cycle();
    @(negedge aclk);
    check("pop+2 s_awvalid", 32'(bus.s_awvalid), 32'd1);
    check("pop+2 s_awid",    32'(bus.s_awid),    32'h11);
    next_cycle();

    // Reset during an AW hold and mid W burst.
    do_reset();
    drive(4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b1);
    next_cycle();
    next_cycle();
    drive(4'b0010, 1'b0, 4'b0100, 4'b0000, 1'b1);
    @(negedge aclk);
    check("mid beat s_wvalid", 32'(bus.s_wvalid), 32'd1);
    check("mid beat w_sel",    32'(bus.w_sel),    32'd2);
    next_cycle();
    @(negedge aclk);
    check("mid hold s_awvalid", 32'(bus.s_awvalid), 32'd1);
    check("mid hold s_awid",    32'(bus.s_awid),    32'h25);
    #1 aresetn = 1'b0;
    #1 check_all_zero("mid_reset");
    drive(4'b1110, 1'b1, 4'b0100, 4'b0100, 1'b1);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    check("post c0 s_awvalid", 32'(bus.s_awvalid), 32'd0);
    check("post c0 s_wvalid",  32'(bus.s_wvalid),  32'd0);
    check("post c0 m_wready",  32'(bus.m_wready),  32'd0);
    next_cycle();
    @(negedge aclk);
    check("post c1 s_awvalid", 32'(bus.s_awvalid), 32'd1);
    check("post c1 s_awid",    32'(bus.s_awid),    32'h25);
    check("post c1 m_awready", 32'(bus.m_awready), 32'h2);
    check("post c1 s_wvalid",  32'(bus.s_wvalid),  32'd0);
    next_cycle();
    bus.m_awvalid = 4'b0000;
    @(negedge aclk);
    check("post c2 s_wvalid", 32'(bus.s_wvalid), 32'd0);
    check("post c2 w_sel",    32'(bus.w_sel),    32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
